lcb_rx_frame: RTL and testbench

Receive-side frame collector between a `uartRx` byte receiver and the read arbiter/packers in the orbit-telemetry path. It takes validated bytes from one LCB RS-485 channel and stores one answer frame in an internal byte buffer. Frame ends are detected by byte count or by inter-byte silence. It raises `oFull` when a complete frame is ready and serves registered random-access reads until the arbiter releases it. One instance per UART channel; it replaces the counter/RAM pair on that channel.

---
 rtl/lcb_rx_frame_if.sv | 26 ++
 rtl/lcb_rx_frame.sv | 166 ++++++++++++++++
 tb/tb_lcb_rx_frame.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/lcb_rx_frame_if.sv
// Byte-in / frame-out bundle between the UART receiver, the frame collector and the read arbiter.
interface lcb_rx_frame_if #(
   parameter int AW = 5
);
   logic          iValid;
   logic [7:0]    iData;
   logic          rstTx;
   logic          iAck;
   logic          rdEn;
   logic [AW-1:0] rdAddr;
   logic [7:0]    oData;
   logic          oFull;
   logic [AW-1:0] oCnt;
   logic          oErr;
   logic          oWE;

   modport master (
      output iValid, iData, rstTx, iAck, rdEn, rdAddr,
      input  oData, oFull, oCnt, oErr, oWE
   );

   modport slave (
      input  iValid, iData, rstTx, iAck, rdEn, rdAddr,
      output oData, oFull, oCnt, oErr, oWE
   );
endinterface

// File: rtl/lcb_rx_frame.sv
// LCB answer-frame collector: byte-count or silence framing, held frame served by registered reads.
// Optional trailing modulo-256 checksum check when LCB_RX_CSUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for byte 0 of a new frame
// RECV  | collecting bytes, gap timer running
// DONE  | complete frame held and frozen, oFull high until ack
module lcb_rx_frame #(
   parameter int BYTES = 20,
   parameter int AW    = 5,
   parameter int GAP   = 800
) (
   input logic            clk,
   input logic            rst,
   lcb_rx_frame_if.slave  bus
);
   localparam int GW = $clog2(GAP);

   typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          err_q, err_d;
   logic          we_q, we_d;
   logic [AW-1:0] wa_d;
   logic [7:0]    rdata_q;
   logic [7:0]    mem_q [2**AW];
   logic          rtx_s1_q, rtx_s2_q, rtx_prev_q;
   logic          rtx_rise;
`ifdef LCB_RX_CSUM_EN
   logic [7:0]    sum_q, sum_d;
`endif

   assign rtx_rise = rtx_s2_q & ~rtx_prev_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         gap_q      <= '0;
         err_q      <= 1'b0;
         we_q       <= 1'b0;
         rdata_q    <= 8'h00;
         rtx_s1_q   <= 1'b0;
         rtx_s2_q   <= 1'b0;
         rtx_prev_q <= 1'b0;
`ifdef LCB_RX_CSUM_EN
         sum_q      <= 8'h00;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
         err_q      <= err_d;
         we_q       <= we_d;
         rtx_s1_q   <= bus.rstTx;
         rtx_s2_q   <= rtx_s1_q;
         rtx_prev_q <= rtx_s2_q;
`ifdef LCB_RX_CSUM_EN
         sum_q      <= sum_d;
`endif
         if (bus.rdEn) rdata_q <= mem_q[bus.rdAddr];
      end
   end

   // Buffer storage has no reset; contents after reset are don't-care.
   always_ff @(posedge clk) begin
      if (we_d) mem_q[wa_d] <= bus.iData;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      err_d   = 1'b0;
      we_d    = 1'b0;
      wa_d    = cnt_q;
`ifdef LCB_RX_CSUM_EN
      sum_d   = sum_q;
`endif
      if (rtx_rise) begin
         state_d = IDLE;
         cnt_d   = '0;
         gap_d   = '0;
         err_d   = ((state_q == DONE) && !bus.iAck) || ((state_q == RECV) && (cnt_q != '0));
`ifdef LCB_RX_CSUM_EN
         sum_d   = 8'h00;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               gap_d = '0;
`ifdef LCB_RX_CSUM_EN
               sum_d = 8'h00;
`endif
               if (bus.iValid) begin
                  we_d    = 1'b1;
                  wa_d    = '0;
                  cnt_d   = AW'(1);
                  state_d = RECV;
`ifdef LCB_RX_CSUM_EN
                  sum_d   = bus.iData;
`endif
               end
            end
            RECV: begin
               if (bus.iValid) begin
                  we_d  = 1'b1;
                  gap_d = '0;
                  cnt_d = cnt_q + AW'(1);
                  if (cnt_q == AW'(BYTES - 1)) begin
`ifdef LCB_RX_CSUM_EN
                     if (bus.iData != sum_q) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                     end else begin
                        state_d = DONE;
                     end
`else
                     state_d = DONE;
`endif
                  end else begin
`ifdef LCB_RX_CSUM_EN
                     sum_d = sum_q + bus.iData;
`endif
                  end
               end else if (gap_q == GW'(GAP - 1)) begin
                  err_d   = 1'b1;
                  cnt_d   = '0;
                  gap_d   = '0;
                  state_d = IDLE;
               end else begin
                  gap_d = gap_q + GW'(1);
               end
            end
            DONE: begin
               // An ack with a coincident byte starts the next frame immediately.
               if (bus.iAck) begin
                  cnt_d   = '0;
                  state_d = IDLE;
                  if (bus.iValid) begin
                     we_d    = 1'b1;
                     wa_d    = '0;
                     cnt_d   = AW'(1);
                     state_d = RECV;
`ifdef LCB_RX_CSUM_EN
                     sum_d   = bus.iData;
`endif
                  end
               end else if (bus.iValid) begin
                  err_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.oData = rdata_q;
   assign bus.oFull = (state_q == DONE);
   assign bus.oCnt  = cnt_q;
   assign bus.oErr  = err_q;
   assign bus.oWE   = we_q;
endmodule

// File: tb/tb_lcb_rx_frame.sv
// Directed bench for lcb_rx_frame: framing, timeout boundary, overrun, ack/byte overlap, rstTx abort, async reset.
module tb_lcb_rx_frame;
   localparam int BYTES = 20;
   localparam int AW    = 5;
   localparam int GAP   = 800;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   err_seen = 0;
   int   base_err;
   logic [7:0] last_b;

   lcb_rx_frame_if #(.AW(AW)) bus ();

   lcb_rx_frame #(.BYTES(BYTES), .AW(AW), .GAP(GAP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (bus.oErr === 1'b1) err_seen <= err_seen + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.iData  = b;
      bus.iValid = 1'b1;
      tick();
      bus.iValid = 1'b0;
   endtask

   // Sends bytes from..BYTES-1 valued base+i; the last byte carries the sum when checksums are enabled.
   task automatic send_rest(input int from, input logic [7:0] base, input logic [7:0] sum_in,
                            output logic [7:0] last);
      logic [7:0] s;
      logic [7:0] b;
      s = sum_in;
      for (int i = from; i < BYTES - 1; i++) begin
         b = base + 8'(i);
         s = s + b;
         send_byte(b);
      end
`ifdef LCB_RX_CSUM_EN
      last = s;
`else
      last = base + 8'(BYTES - 1);
`endif
      send_byte(last);
   endtask

   task automatic rd(input logic [AW-1:0] addr, input logic [7:0] exp, input string tag);
      bus.rdAddr = addr;
      bus.rdEn   = 1'b1;
      tick();
      bus.rdEn   = 1'b0;
      chk(tag, 32'(bus.oData), 32'(exp));
   endtask

   initial begin
      bus.iValid = 1'b0;
      bus.iData  = 8'h00;
      bus.rstTx  = 1'b0;
      bus.iAck   = 1'b0;
      bus.rdEn   = 1'b0;
      bus.rdAddr = '0;

      repeat (3) tick();
      chk("rst_full", 32'(bus.oFull), 32'd0);
      chk("rst_cnt",  32'(bus.oCnt),  32'd0);
      chk("rst_err",  32'(bus.oErr),  32'd0);
      chk("rst_we",   32'(bus.oWE),   32'd0);
      chk("rst_data", 32'(bus.oData), 32'd0);
      rst = 1'b1;
      repeat (2) tick();

      // normal frame 0x00..
      for (int i = 0; i < BYTES - 1; i++) begin
         send_byte(8'(i));
         if (i == 0) begin
            chk("we_pulse", 32'(bus.oWE), 32'd1);
            chk("cnt_1",    32'(bus.oCnt), 32'd1);
         end
      end
      chk("full_before_last", 32'(bus.oFull), 32'd0);
      chk("cnt_19",           32'(bus.oCnt),  32'd19);
`ifdef LCB_RX_CSUM_EN
      last_b = 8'hAB;
`else
      last_b = 8'h13;
`endif
      send_byte(last_b);
      chk("full_after_last", 32'(bus.oFull), 32'd1);
      chk("cnt_20",          32'(bus.oCnt),  32'd20);
      rd(5'd5, 8'h05, "rd_addr5");
      rd(5'd19, last_b, "rd_addr19");
      bus.rdAddr = 5'd3;
      tick();
      chk("rd_hold", 32'(bus.oData), 32'(last_b));

      // overrun while held
      base_err = err_seen;
      send_byte(8'hFF);
      send_byte(8'hFF);
      send_byte(8'hFF);
      tick();
      chk("overrun_errs", 32'(err_seen - base_err), 32'd3);
      chk("overrun_full", 32'(bus.oFull), 32'd1);
      chk("overrun_cnt",  32'(bus.oCnt),  32'd20);
      rd(5'd0, 8'h00, "overrun_buf0");
      rd(5'd1, 8'h01, "overrun_buf1");
      bus.iAck = 1'b1;
      tick();
      bus.iAck = 1'b0;
      chk("ack_full", 32'(bus.oFull), 32'd0);
      chk("ack_cnt",  32'(bus.oCnt),  32'd0);

      // short frame and timeout boundary
      base_err = err_seen;
      for (int i = 0; i < 7; i++) send_byte(8'h30 + 8'(i));
      repeat (GAP - 1) tick();
      chk("gap_edge_cnt", 32'(bus.oCnt), 32'd7);
      chk("gap_edge_err", 32'(bus.oErr), 32'd0);
      tick();
      chk("timeout_cnt", 32'(bus.oCnt), 32'd0);
      chk("timeout_err", 32'(bus.oErr), 32'd1);
      tick();
      chk("timeout_errs", 32'(err_seen - base_err), 32'd1);
      chk("timeout_full", 32'(bus.oFull), 32'd0);

      // byte arrives in the timeout cycle: byte wins
      base_err = err_seen;
      send_byte(8'h40);
      repeat (GAP - 1) tick();
      send_rest(1, 8'h40, 8'h40, last_b);
      tick();
      chk("tie_errs", 32'(err_seen - base_err), 32'd0);
      chk("tie_full", 32'(bus.oFull), 32'd1);
      chk("tie_cnt",  32'(bus.oCnt),  32'd20);
      rd(5'd7, 8'h47, "tie_rd7");

      // ack coincident with a new byte
      base_err = err_seen;
      bus.iAck   = 1'b1;
      bus.iValid = 1'b1;
      bus.iData  = 8'hA5;
      tick();
      bus.iAck   = 1'b0;
      bus.iValid = 1'b0;
      chk("ackv_full", 32'(bus.oFull), 32'd0);
      chk("ackv_cnt",  32'(bus.oCnt),  32'd1);
      rd(5'd0, 8'hA5, "ackv_rd0");
      send_rest(1, 8'h60, 8'hA5, last_b);
      tick();
      chk("ackv_errs", 32'(err_seen - base_err), 32'd0);
      chk("ackv_frame_full", 32'(bus.oFull), 32'd1);

      // rstTx rise while frame held
      base_err = err_seen;
      bus.rstTx = 1'b1;
      tick();
      chk("rtx_e1_full", 32'(bus.oFull), 32'd1);
      tick();
      chk("rtx_e2_full", 32'(bus.oFull), 32'd1);
      tick();
      chk("rtx_e3_full", 32'(bus.oFull), 32'd0);
      chk("rtx_e3_cnt",  32'(bus.oCnt),  32'd0);
      chk("rtx_e3_err",  32'(bus.oErr),  32'd1);
      tick();
      chk("rtx_errs", 32'(err_seen - base_err), 32'd1);
      bus.rstTx = 1'b0;
      repeat (3) tick();

      // rstTx rise in IDLE is silent
      base_err = err_seen;
      bus.rstTx = 1'b1;
      repeat (5) tick();
      chk("rtx_idle_errs", 32'(err_seen - base_err), 32'd0);
      bus.rstTx = 1'b0;
      repeat (3) tick();

      // async reset mid-RECV
      send_byte(8'h71);
      send_byte(8'h72);
      bus.rdAddr = 5'd0;
      bus.rdEn   = 1'b1;
      send_byte(8'h73);
      bus.rdEn   = 1'b0;
      chk("pre_rst_cnt",  32'(bus.oCnt),  32'd3);
      chk("pre_rst_we",   32'(bus.oWE),   32'd1);
      chk("pre_rst_data", 32'(bus.oData), 32'h71);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_cnt",  32'(bus.oCnt),  32'd0);
      chk("arst_we",   32'(bus.oWE),   32'd0);
      chk("arst_data", 32'(bus.oData), 32'd0);
      chk("arst_full", 32'(bus.oFull), 32'd0);
      chk("arst_err",  32'(bus.oErr),  32'd0);
      tick();
      rst = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
